prng_stream: RTL and testbench
==============================

PRNG_STREAM -- requirements
Module: prng_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 32, lane word width; only 32 and 64 legal, any other value SHALL fail elaboration.
REQ-002 Parameter LANES, default 4, independent generator lanes, legal range 1..8.
REQ-003 Parameter CNT_W, default 16, width of burst length and word counter.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  in IDLE: latch seed and burst_len and begin a burst; ignored otherwise.
REQ-007 re_start  input  1  in SEED, FILL or RUN: reseed from seed input and restart the count; ignored in IDLE.
REQ-008 stop  input  1  abort any burst, return to IDLE.
REQ-009 seed  input  DATA_WIDTH  base seed, sampled only with accepted start/re_start.
REQ-010 burst_len  input  CNT_W  words per burst, sampled with accepted start/re_start; 0 = continuous.
REQ-011 out_ready  input  1  consumer accepts data_out this cycle.
REQ-012 out_valid  output  1  data_out holds a valid word.
REQ-013 data_out  output  LANES*DATA_WIDTH  lane i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-014 end_random  output  1  one-cycle pulse after the last burst word is accepted.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 word_cnt  output  CNT_W  words accepted in current burst.

Function
REQ-017 FSM states IDLE, SEED, FILL, RUN; IDLE->SEED on start; SEED->FILL and FILL->RUN unconditionally; RUN->IDLE on the final accepted word.
REQ-018 SEED: lane i state <= seed ^ (i*K) mod 2^DATA_WIDTH; K = 0x9E3779B9 (32) or 0x9E3779B97F4A7C15 (64).
REQ-019 SEED: a lane state that would be zero is loaded with K instead (zero guard).
REQ-020 Step function xs(): x^=x<<a; x^=x>>b; x^=x<<c, truncated to DATA_WIDTH; (a,b,c) = (13,17,5) for 32, (13,7,17) for 64.
REQ-021 FILL: each lane state <= xs(state), data_out lane <= same value, out_valid <= 1.
REQ-022 Latency: start sampled at edge T -> out_valid high after edge T+2.
REQ-023 RUN handshake: word transfers on out_valid && out_ready; data_out and out_valid hold stable while out_ready low.
REQ-024 On a transfer that is not the last: state and data_out advance by xs() on the same edge, out_valid stays 1 (one word per cycle at full throughput).
REQ-025 word_cnt increments on every transfer; at 2^CNT_W-1 it wraps to 0, and in continuous mode (burst_len 0) it never terminates the burst.
REQ-026 Last word: transfer with word_cnt == burst_len-1 (burst_len != 0) -> out_valid <= 0, end_random = 1 the next cycle, -> IDLE, word_cnt retains final value.
REQ-027 re_start (SEED/FILL/RUN): -> SEED, out_valid <= 0, word_cnt <= 0, no end_random; a transfer coinciding with re_start is still counted as consumed but ignored.
REQ-028 stop: highest priority over start/re_start/transfer; -> IDLE, out_valid <= 0, end_random not asserted, word_cnt held.
REQ-029 start and re_start in the same IDLE cycle: start wins; in non-IDLE cycle re_start wins and start ignored.
REQ-030 Lanes advance in lockstep; no lane ever holds state zero.

Reset
REQ-031 rst asserted: immediately, independent of clk, state IDLE, out_valid 0, data_out 0, end_random 0, busy 0, word_cnt 0, all lane states 0.
REQ-032 rst deasserted mid-burst: block stays in IDLE until next start; no stale word is presented.

Verification
REQ-033 DATA_WIDTH 32, LANES 1, seed 1, burst_len 2, out_ready 1 -> out_valid at T+2, words 0x00042021 then 0x04080601, end_random pulse one cycle after second transfer.
REQ-034 Seed 0, LANES 2 -> lane 0 seeded 0x9E3779B9 (zero guard), lane 1 seeded 0x9E3779B9, both lanes emit identical first word xs(0x9E3779B9).
REQ-035 Random out_ready back-pressure over burst_len 100 -> data_out never changes while out_valid && !out_ready, exactly 100 transfers, one end_random.
REQ-036 re_start at word 5 of burst_len 10 with new seed 1 -> out_valid drops, restarts with 0x00042021 two cycles later, word_cnt returns to 0, end_random only after 10 further transfers.
REQ-037 stop during RUN, then rst asserted mid-cycle -> out_valid falls without end_random; rst forces all outputs 0 asynchronously before next clk edge.
REQ-038 burst_len 0, CNT_W 4, 20 transfers -> word_cnt wraps 15->0, out_valid remains 1, no end_random.

Source files
------------

// File: rtl/prng_stream.sv
// prng_stream
//   Multi-lane xorshift pseudo-random word generator with burst control and a
//   valid/ready output handshake. All lanes step in lockstep from one shared
//   seed, each lane offset by a multiple of the golden-ratio constant K.
//
// Parameters
//   DATA_WIDTH  lane word width, 32 or 64
//   LANES       number of generator lanes, 1..8
//   CNT_W       width of burst length and word counter
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   start       begin a burst (IDLE only), samples seed and burst_len
//   re_start    reseed and restart the count (SEED/FILL/RUN only)
//   stop        abort any burst, highest priority
//   seed        base seed, sampled with accepted start/re_start
//   burst_len   words per burst, 0 = continuous
//   out_ready   consumer accepts data_out this cycle
//   out_valid   data_out holds a valid word
//   data_out    lane i in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   end_random  one-cycle pulse after the last burst word is accepted
//   busy        high in any state other than IDLE
//   word_cnt    words accepted in the current burst
module prng_stream #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LANES      = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        re_start,
   input  logic                        stop,
   input  logic [DATA_WIDTH-1:0]       seed,
   input  logic [CNT_W-1:0]            burst_len,
   input  logic                        out_ready,
   output logic                        out_valid,
   output logic [LANES*DATA_WIDTH-1:0] data_out,
   output logic                        end_random,
   output logic                        busy,
   output logic [CNT_W-1:0]            word_cnt
);

   // Parameter legality is checked at elaboration.
   if (!((DATA_WIDTH == 32) || (DATA_WIDTH == 64))) begin : g_bad_width
      $error("prng_stream: DATA_WIDTH must be 32 or 64");
   end
   if ((LANES < 1) || (LANES > 8)) begin : g_bad_lanes
      $error("prng_stream: LANES must be in 1..8");
   end

   localparam int unsigned LW = LANES * DATA_WIDTH;

   // Golden-ratio constant, used both as lane offset and as zero-seed substitute.
   localparam logic [63:0] KSel = (DATA_WIDTH == 64) ? 64'h9E37_79B9_7F4A_7C15
                                                     : 64'h0000_0000_9E37_79B9;
   localparam logic [DATA_WIDTH-1:0] K = KSel[DATA_WIDTH-1:0];

   // Xorshift triple for the selected width.
   localparam int unsigned ShA = 13;
   localparam int unsigned ShB = (DATA_WIDTH == 64) ? 7 : 17;
   localparam int unsigned ShC = (DATA_WIDTH == 64) ? 17 : 5;

   function automatic logic [DATA_WIDTH-1:0] xs(input logic [DATA_WIDTH-1:0] x);
      logic [DATA_WIDTH-1:0] t;
      t = x ^ (x << ShA);
      t = t ^ (t >> ShB);
      t = t ^ (t << ShC);
      return t;
   endfunction

   typedef enum logic [1:0] {
      StIdle,
      StSeed,
      StFill,
      StRun
   } state_e;

   state_e            state_q, state_d;
   logic [LW-1:0]     lane_q, lane_d;
   logic [LW-1:0]     data_q, data_d;
   logic              valid_q, valid_d;
   logic              end_q, end_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] seed_q, seed_d;
   logic [CNT_W-1:0]  len_q, len_d;

   logic [LW-1:0]     seed_all;
   logic [LW-1:0]     step_all;
   logic              xfer;
   logic              last;

   // Per-lane seeding and stepping, all lanes computed in parallel.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      localparam logic [DATA_WIDTH-1:0] Off = K * DATA_WIDTH'(i);
      logic [DATA_WIDTH-1:0] mixed;

      assign mixed = seed_q ^ Off;
      // A zero xorshift state would stick at zero forever.
      assign seed_all[i*DATA_WIDTH +: DATA_WIDTH] = (mixed == '0) ? K : mixed;
      assign step_all[i*DATA_WIDTH +: DATA_WIDTH] = xs(lane_q[i*DATA_WIDTH +: DATA_WIDTH]);
   end

   // out_valid is only ever set in RUN, so it qualifies the transfer by itself.
   assign xfer = valid_q && out_ready;
   assign last = (len_q != '0) && (cnt_q == (len_q - CNT_W'(1)));

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      data_d  = data_q;
      valid_d = valid_q;
      end_d   = 1'b0;
      cnt_d   = cnt_q;
      seed_d  = seed_q;
      len_d   = len_q;

      if (stop) begin
         state_d = StIdle;
         valid_d = 1'b0;
      end else if (state_q == StIdle) begin
         if (start) begin
            seed_d  = seed;
            len_d   = burst_len;
            cnt_d   = '0;
            state_d = StSeed;
         end
      end else if (re_start) begin
         // Any coincident transfer is dropped: the count restarts from zero.
         seed_d  = seed;
         len_d   = burst_len;
         cnt_d   = '0;
         valid_d = 1'b0;
         state_d = StSeed;
      end else begin
         unique case (state_q)
            StSeed: begin
               lane_d  = seed_all;
               state_d = StFill;
            end
            StFill: begin
               lane_d  = step_all;
               data_d  = step_all;
               valid_d = 1'b1;
               state_d = StRun;
            end
            StRun: begin
               if (xfer) begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (last) begin
                     valid_d = 1'b0;
                     end_d   = 1'b1;
                     state_d = StIdle;
                  end else begin
                     lane_d = step_all;
                     data_d = step_all;
                  end
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         lane_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         end_q   <= 1'b0;
         cnt_q   <= '0;
         seed_q  <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         end_q   <= end_d;
         cnt_q   <= cnt_d;
         seed_q  <= seed_d;
         len_q   <= len_d;
      end
   end

   assign out_valid  = valid_q;
   assign data_out   = data_q;
   assign end_random = end_q;
   assign busy       = (state_q != StIdle);
   assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_prng_stream.sv
// tb_prng_stream
//   Directed bench for prng_stream. Three instances share the stimulus:
//   dut_a (32-bit, 2 lanes, 16-bit count), dut_b (32-bit, 1 lane, 4-bit count
//   for wrap checks) and dut_c (64-bit, 2 lanes).
module tb_prng_stream;

   logic        clk;
   logic        rst;
   logic        start;
   logic        re_start;
   logic        stop;
   logic [63:0] seed;
   logic [15:0] burst_len;
   logic        out_ready;

   logic        a_valid, a_end, a_busy;
   logic [63:0] a_data;
   logic [15:0] a_cnt;

   logic        b_valid, b_end, b_busy;
   logic [31:0] b_data;
   logic [3:0]  b_cnt;

   logic         c_valid, c_end, c_busy;
   logic [127:0] c_data;
   logic [15:0]  c_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   prng_stream #(.DATA_WIDTH(32), .LANES(2), .CNT_W(16)) dut_a (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .re_start   (re_start),
      .stop       (stop),
      .seed       (seed[31:0]),
      .burst_len  (burst_len),
      .out_ready  (out_ready),
      .out_valid  (a_valid),
      .data_out   (a_data),
      .end_random (a_end),
      .busy       (a_busy),
      .word_cnt   (a_cnt)
   );

   prng_stream #(.DATA_WIDTH(32), .LANES(1), .CNT_W(4)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .re_start   (re_start),
      .stop       (stop),
      .seed       (seed[31:0]),
      .burst_len  (burst_len[3:0]),
      .out_ready  (out_ready),
      .out_valid  (b_valid),
      .data_out   (b_data),
      .end_random (b_end),
      .busy       (b_busy),
      .word_cnt   (b_cnt)
   );

   prng_stream #(.DATA_WIDTH(64), .LANES(2), .CNT_W(16)) dut_c (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .re_start   (re_start),
      .stop       (stop),
      .seed       (seed),
      .burst_len  (burst_len),
      .out_ready  (out_ready),
      .out_valid  (c_valid),
      .data_out   (c_data),
      .end_random (c_end),
      .busy       (c_busy),
      .word_cnt   (c_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] xs32(input logic [31:0] x);
      x = x ^ (x << 13);
      x = x ^ (x >> 17);
      x = x ^ (x << 5);
      return x;
   endfunction

   function automatic logic [63:0] xs64(input logic [63:0] x);
      x = x ^ (x << 13);
      x = x ^ (x >> 7);
      x = x ^ (x << 17);
      return x;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; sample point is 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_burst(input logic [63:0] s, input logic [15:0] len);
      seed      = s;
      burst_len = len;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [31:0] model;
   logic [31:0] prev_data;
   logic        prev_stall;
   logic        rdy;
   int          n_xfer;
   int          n_end;

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      re_start  = 1'b0;
      stop      = 1'b0;
      seed      = '0;
      burst_len = '0;
      out_ready = 1'b0;
      tick();
      check("rst_valid", 64'(a_valid), 64'd0);
      check("rst_data",  a_data, 64'd0);
      check("rst_busy",  64'(a_busy), 64'd0);
      check("rst_cnt",   64'(a_cnt), 64'd0);
      check("rst_end",   64'(a_end), 64'd0);
      #2 rst = 1'b0;
      tick();

      // Basic burst: seed 1, two words, full throughput.
      out_ready = 1'b1;
      begin_burst(64'd1, 16'd2);
      check("b1_busy",    64'(a_busy), 64'd1);
      check("b1_valid_t1", 64'(a_valid), 64'd0);
      tick();
      check("b1_valid_t2", 64'(a_valid), 64'd0);
      tick();
      check("b1_valid",   64'(a_valid), 64'd1);
      check("b1_word0",   64'(a_data[31:0]), 64'h0004_2021);
      check("b1_lane1",   64'(a_data[63:32]), 64'(xs32(32'h9E37_79B8)));
      check("b1_cnt0",    64'(a_cnt), 64'd0);
      check("b1_c_lane0", c_data[63:0], xs64(64'd1));
      check("b1_c_lane1", c_data[127:64], xs64(64'h9E37_79B9_7F4A_7C14));
      tick();
      check("b1_word1",   64'(a_data[31:0]), 64'h0408_0601);
      check("b1_cnt1",    64'(a_cnt), 64'd1);
      check("b1_end_mid", 64'(a_end), 64'd0);
      tick();
      check("b1_end",     64'(a_end), 64'd1);
      check("b1_valid_lo", 64'(a_valid), 64'd0);
      check("b1_idle",    64'(a_busy), 64'd0);
      check("b1_cnt_fin", 64'(a_cnt), 64'd2);
      tick();
      check("b1_end_pulse", 64'(a_end), 64'd0);

      // Zero seed: both lanes fall back to K and emit the same first word.
      out_ready = 1'b0;
      begin_burst(64'd0, 16'd3);
      tick();
      tick();
      check("z_lane0", 64'(a_data[31:0]), 64'(xs32(32'h9E37_79B9)));
      check("z_lane1", 64'(a_data[63:32]), 64'(xs32(32'h9E37_79B9)));
      check("z_c_lane0", c_data[63:0], xs64(64'h9E37_79B9_7F4A_7C15));
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("z_stop_valid", 64'(a_valid), 64'd0);
      check("z_stop_busy",  64'(a_busy), 64'd0);
      check("z_stop_end",   64'(a_end), 64'd0);

      // Random back-pressure over a 100-word burst.
      begin_burst(64'h1234_5678, 16'd100);
      model      = xs32(32'h1234_5678);
      prev_stall = 1'b0;
      prev_data  = '0;
      n_xfer     = 0;
      n_end      = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         if (prev_stall) begin
            check("bp_vhold", 64'(a_valid), 64'd1);
            check("bp_hold",  64'(a_data[31:0]), 64'(prev_data));
         end
         rdy        = 1'($urandom_range(0, 1));
         out_ready  = rdy;
         prev_stall = a_valid && !rdy;
         prev_data  = a_data[31:0];
         if (a_valid && rdy) begin
            check("bp_word", 64'(a_data[31:0]), 64'(model));
            model = xs32(model);
            n_xfer++;
         end
         tick();
         if (a_end) n_end++;
         if (!a_busy) break;
      end
      check("bp_count", 64'(n_xfer), 64'd100);
      check("bp_ends",  64'(n_end), 64'd1);

      // re_start at word 5 of a 10-word burst, reseeding with 1.
      out_ready = 1'b1;
      begin_burst(64'h0BAD_F00D, 16'd10);
      tick();
      tick();
      for (int k = 0; k < 5; k++) tick();
      check("rs_cnt5", 64'(a_cnt), 64'd5);
      seed     = 64'd1;
      re_start = 1'b1;
      start    = 1'b1;
      tick();
      re_start = 1'b0;
      start    = 1'b0;
      check("rs_valid_drop", 64'(a_valid), 64'd0);
      check("rs_cnt_clr",    64'(a_cnt), 64'd0);
      check("rs_no_end",     64'(a_end), 64'd0);
      check("rs_busy",       64'(a_busy), 64'd1);
      tick();
      check("rs_valid_fill", 64'(a_valid), 64'd0);
      tick();
      check("rs_valid", 64'(a_valid), 64'd1);
      check("rs_word0", 64'(a_data[31:0]), 64'h0004_2021);
      n_xfer = 0;
      n_end  = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (a_valid && out_ready) begin
            if (n_xfer == 1) check("rs_word1", 64'(a_data[31:0]), 64'h0408_0601);
            n_xfer++;
         end
         tick();
         if (a_end) begin
            n_end++;
            break;
         end
      end
      check("rs_xfers", 64'(n_xfer), 64'd10);
      check("rs_end",   64'(n_end), 64'd1);
      check("rs_cnt_fin", 64'(a_cnt), 64'd10);

      // stop during RUN, then asynchronous reset mid-burst.
      begin_burst(64'h55, 16'd50);
      tick();
      tick();
      tick();
      tick();
      check("st_cnt2", 64'(a_cnt), 64'd2);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("st_valid", 64'(a_valid), 64'd0);
      check("st_end",   64'(a_end), 64'd0);
      check("st_busy",  64'(a_busy), 64'd0);
      check("st_cnt",   64'(a_cnt), 64'd2);
      tick();
      check("st_end2",  64'(a_end), 64'd0);
      begin_burst(64'h55, 16'd50);
      tick();
      tick();
      check("ar_pre_valid", 64'(a_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("ar_valid", 64'(a_valid), 64'd0);
      check("ar_data",  a_data, 64'd0);
      check("ar_busy",  64'(a_busy), 64'd0);
      check("ar_cnt",   64'(a_cnt), 64'd0);
      check("ar_end",   64'(a_end), 64'd0);
      check("ar_c_data", c_data[63:0], 64'd0);
      tick();
      #2 rst = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      check("ar_stay_idle",  64'(a_busy), 64'd0);
      check("ar_stay_valid", 64'(a_valid), 64'd0);

      // Continuous mode with a 4-bit counter: wraps, never ends.
      seed      = 64'd1;
      burst_len = 16'd0;
      start     = 1'b1;
      re_start  = 1'b1;
      tick();
      start     = 1'b0;
      re_start  = 1'b0;
      check("ct_busy", 64'(b_busy), 64'd1);
      tick();
      tick();
      check("ct_valid", 64'(b_valid), 64'd1);
      check("ct_word0", 64'(b_data), 64'h0004_2021);
      model = xs32(32'h0004_2021);
      for (int k = 1; k <= 20; k++) begin
         tick();
         check("ct_cnt",   64'(b_cnt), 64'(k % 16));
         check("ct_valid", 64'(b_valid), 64'd1);
         check("ct_noend", 64'(b_end), 64'd0);
         check("ct_word",  64'(b_data), 64'(model));
         model = xs32(model);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("ct_stop_busy", 64'(b_busy), 64'd0);
      check("ct_stop_end",  64'(b_end), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
